// File: rtl/serial_subtractor_pkg.sv
// Shared FSM state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fs_d, fs_bout;
    logic             accept, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .bin (br_q),
        .d   (fs_d),
        .bout(fs_bout)
    );

    assign accept = start && (state_q != S_SHIFT);
    assign last   = (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_SHIFT: begin
                r_sr_d = {fs_d, r_sr_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                // Final bit: publish the completed result alongside done.
                if (last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = {fs_d, r_sr_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        // A start in IDLE or DONE overrides the default transition.
        if (accept) begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            a_sr_d  = a;
            b_sr_d  = b;
            br_d    = bin;
            cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, bin;
    logic [7:0] a, b;
    logic       busy, done, bout;
    logic [7:0] diff;
    logic       start4, bin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .start(start4),
        .a    (a4),
        .b    (b4),
        .bin  (bin4),
        .busy (busy4),
        .done (done4),
        .diff (diff4),
        .bout (bout4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf4)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Raise start with operands (called just after a rising edge) and wait
    // for done; cyc counts edges from the sampling edge up to done.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                      output int cyc, output int bcyc);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        cyc = 0; bcyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy) bcyc++;
        end while (!done && cyc < 30);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc, bcyc, n, r;
        logic [4:0] exp5;

        vecs[0] = '{8'd20,  8'd7,   1'b0, 8'd13,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   1'b0, 8'hFC,  1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1, 1'b0};
        vecs[3] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
        vecs[4] = '{8'h10,  8'h01,  1'b0, 8'h0F,  1'b0, 1'b0};
        vecs[5] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0};
        vecs[6] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].bin, cyc, bcyc);
            check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
            check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].exp_bout));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
            if (i == 0) begin
                check("latency_cycles", 32'(cyc), 32'd9);
                check("busy_cycles", 32'(bcyc), 32'd8);
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_diff_held", i), 32'(diff), 32'(vecs[i].exp_diff));
        end

        // start pulsed mid-operation must be ignored.
        a = 8'd100; b = 8'd30; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'd1; b = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("ignore_done", 32'(done), 32'd1);
        check("ignore_diff", 32'(diff), 32'd70);
        check("ignore_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;

        // start held during done: next operation follows with no gap.
        op(8'd50, 8'd8, 1'b0, cyc, bcyc);
        check("b2b_first_diff", 32'(diff), 32'd42);
        a = 8'd9; b = 8'd10; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy_nogap", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("b2b_diff_stable", 32'(diff), 32'd42);
        wait_done(cyc);
        check("b2b_second_diff", 32'(diff), 32'hFF);
        check("b2b_second_bout", 32'(bout), 32'd1);
        @(posedge clk); #1;

        // rst on the third SHIFT cycle aborts the operation.
        a = 8'd200; b = 8'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        op(8'd3, 8'd3, 1'b0, cyc, bcyc);
        check("post_reset_done", 32'(done), 32'd1);
        check("post_reset_diff", 32'(diff), 32'd0);
        check("post_reset_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;

        // Exhaustive WIDTH=4 sweep against {bout,diff} = a - b - bin.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    r = ai - bi - ci;
                    exp5 = r[4:0];
                    check($sformatf("w4_%0d_%0d_%0d", ai, bi, ci),
                          32'({bout4, diff4}), 32'(exp5));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
